seq6_match: RTL and testbench

- 6-bit sequential match generator. It is the driving end of the 6-bit equality compare path.
- It loads a start value and steps a counter one per clock until the counter equals a programmed target. It then reports completion through a start/done handshake.
- It also drives an active-low equality flag (equal_n) with the same polarity as the existing 6-bit compare cells. Downstream logic can therefore use either source without change.
- It sits beside the compare logic in the Tom timing/object path, where it generates the compare stimulus.

---
 rtl/seq6_match.sv | 112 +++++++++++
 tb/tb_seq6_match.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq6_match.sv
// 6-bit sequential match generator: steps a counter from a loaded start value
// until it equals a latched target, then reports completion via start/done/ack.
module seq6_match #(
    parameter int STEP   = 1,
    parameter int MAXCYC = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] start_val,
    input  logic [5:0] target,
    input  logic       wrap_en,
    input  logic       ack,
    output logic [5:0] count,
    output logic       busy,
    output logic       done,
    output logic       equal_n,
    output logic [1:0] status
);

    localparam int            CW       = (MAXCYC > 1) ? $clog2(MAXCYC) : 1;
    localparam logic [6:0]    STEP7    = 7'(STEP % 64);
    localparam logic [CW-1:0] CYC_LAST = CW'(MAXCYC - 1);

    localparam logic [1:0] ST_MATCH   = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_OVFL    = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [5:0]    count_q, count_d;
    logic [5:0]    tgt_q, tgt_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [1:0]    status_q, status_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [6:0]    sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            tgt_q    <= '0;
            cyc_q    <= '0;
            status_q <= ST_MATCH;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tgt_q    <= tgt_d;
            cyc_q    <= cyc_d;
            status_q <= status_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Carry out of the 7-bit sum marks a step past 63.
    assign sum = {1'b0, count_q} + STEP7;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tgt_d    = tgt_q;
        cyc_d    = cyc_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = start_val;
                    tgt_d   = target;
                    cyc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (count_q == tgt_q) begin
                    status_d = ST_MATCH;
                    state_d  = DONE;
                end else if (cyc_q == CYC_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = DONE;
                end else if (!wrap_en && sum[6]) begin
                    status_d = ST_OVFL;
                    state_d  = DONE;
                end else begin
                    count_d = sum[5:0];
                    cyc_d   = cyc_q + CW'(1);
                end
            end
            DONE: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they land in flops.
    always_comb begin
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
        equal_n = ~&(count_q ~^ tgt_q);
    end

    assign count  = count_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign status = status_q;

endmodule

// File: tb/tb_seq6_match.sv
// Bench for seq6_match: scoreboarded completions on a STEP=1 and a STEP=2 instance.
module tb_seq6_match;

    logic       clk = 1'b0;
    logic       reset, start1, start2, wrap_en, ack;
    logic [5:0] start_val, target;
    logic [5:0] count1, count2;
    logic       busy1, busy2, done1, done2, equal_n1, equal_n2;
    logic [1:0] status1, status2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] st;
        logic [5:0] cnt;
        int         lat;
        int         t0;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq6_match #(.STEP(1), .MAXCYC(64)) u1 (
        .clk(clk), .reset(reset), .start(start1), .start_val(start_val),
        .target(target), .wrap_en(wrap_en), .ack(ack), .count(count1),
        .busy(busy1), .done(done1), .equal_n(equal_n1), .status(status1)
    );

    seq6_match #(.STEP(2), .MAXCYC(64)) u2 (
        .clk(clk), .reset(reset), .start(start2), .start_val(start_val),
        .target(target), .wrap_en(wrap_en), .ack(ack), .count(count2),
        .busy(busy2), .done(done2), .equal_n(equal_n2), .status(status2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops an expectation on every rising done and checks result and latency.
    task automatic monitor();
        logic d1p = 1'b0;
        logic d2p = 1'b0;
        exp_t e;
        forever begin
            tick();
            checks++;
            if ((busy1 && done1) || (busy2 && done2)) begin
                errors++;
                $display("FAIL excl: busy1=%b done1=%b busy2=%b done2=%b", busy1, done1, busy2, done2);
            end
            if (done1 === 1'b1 && !d1p) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sb1_unexpected: done rose with empty queue, count=%0d", count1);
                end else begin
                    e = q1.pop_front();
                    if (status1 !== e.st || count1 !== e.cnt || (cyc - e.t0) != e.lat) begin
                        errors++;
                        $display("FAIL sb1: got status=%0d count=%0d lat=%0d, want status=%0d count=%0d lat=%0d",
                                 status1, count1, cyc - e.t0, e.st, e.cnt, e.lat);
                    end
                end
            end
            if (done2 === 1'b1 && !d2p) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL sb2_unexpected: done rose with empty queue, count=%0d", count2);
                end else begin
                    e = q2.pop_front();
                    if (status2 !== e.st || count2 !== e.cnt || (cyc - e.t0) != e.lat) begin
                        errors++;
                        $display("FAIL sb2: got status=%0d count=%0d lat=%0d, want status=%0d count=%0d lat=%0d",
                                 status2, count2, cyc - e.t0, e.st, e.cnt, e.lat);
                    end
                end
            end
            d1p = (done1 === 1'b1);
            d2p = (done2 === 1'b1);
        end
    endtask

    // Drives one start pulse on u1; the capture edge is the next posedge.
    task automatic kick1(input logic [5:0] sv, input logic [5:0] tg, input logic wr,
                         input bit push, input logic [1:0] es, input logic [5:0] ec, input int el);
        exp_t e;
        start_val = sv; target = tg; wrap_en = wr; start1 = 1'b1;
        if (push) begin
            e.st = es; e.cnt = ec; e.lat = el; e.t0 = cyc + 1;
            q1.push_back(e);
        end
        tick();
        start1 = 1'b0;
    endtask

    task automatic wait_done1(input int bound);
        int n = 0;
        while (done1 !== 1'b1 && n < bound) begin tick(); n++; end
        checks++;
        if (done1 !== 1'b1) begin
            errors++;
            $display("FAIL wait_done1: done=%b after %0d cycles, want 1", done1, bound);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL ack: done=%b busy=%b, want 0 0", done1, busy1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        checks++;
        if (count1 !== 6'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || status1 !== 2'd0 || equal_n1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_u1: count=%0d busy=%b done=%b status=%0d eq_n=%b, want 0 0 0 0 0",
                     count1, busy1, done1, status1, equal_n1);
        end
        checks++;
        if (count2 !== 6'd0 || busy2 !== 1'b0 || done2 !== 1'b0 || status2 !== 2'd0 || equal_n2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_u2: count=%0d busy=%b done=%b status=%0d eq_n=%b, want 0 0 0 0 0",
                     count2, busy2, done2, status2, equal_n2);
        end
    endtask

    task automatic test_plain();
        kick1(6'd5, 6'd9, 1'b0, 1, 2'd0, 6'd9, 5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0 || count1 !== 6'(5 + i)) begin
                errors++;
                $display("FAIL plain_run[%0d]: busy=%b done=%b count=%0d, want 1 0 %0d", i, busy1, done1, count1, 5 + i);
            end
            tick();
        end
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || status1 !== 2'd0 || count1 !== 6'd9 || equal_n1 !== 1'b0) begin
            errors++;
            $display("FAIL plain_done: done=%b busy=%b status=%0d count=%0d eq_n=%b, want 1 0 0 9 0",
                     done1, busy1, status1, count1, equal_n1);
        end
        do_ack();
    endtask

    task automatic test_immediate();
        kick1(6'd12, 6'd12, 1'b0, 1, 2'd0, 6'd12, 1);
        checks++;
        if (busy1 !== 1'b1 || count1 !== 6'd12 || equal_n1 !== 1'b0) begin
            errors++;
            $display("FAIL imm_run: busy=%b count=%0d eq_n=%b, want 1 12 0", busy1, count1, equal_n1);
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || count1 !== 6'd12 || equal_n1 !== 1'b0) begin
            errors++;
            $display("FAIL imm_done: done=%b count=%0d eq_n=%b, want 1 12 0", done1, count1, equal_n1);
        end
        do_ack();
    endtask

    task automatic test_wrap_en();
        logic [5:0] seq [4] = '{6'd62, 6'd63, 6'd0, 6'd1};
        kick1(6'd62, 6'd1, 1'b1, 1, 2'd0, 6'd1, 4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy1 !== 1'b1 || count1 !== seq[i]) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: busy=%b count=%0d, want 1 %0d", i, busy1, count1, seq[i]);
            end
            tick();
        end
        checks++;
        if (done1 !== 1'b1 || status1 !== 2'd0) begin
            errors++;
            $display("FAIL wrap_done: done=%b status=%0d, want 1 0", done1, status1);
        end
        do_ack();
    endtask

    task automatic test_wrap_dis();
        kick1(6'd62, 6'd1, 1'b0, 1, 2'd2, 6'd63, 2);
        wait_done1(10);
        checks++;
        if (status1 !== 2'd2 || count1 !== 6'd63) begin
            errors++;
            $display("FAIL ovfl: status=%0d count=%0d, want 2 63", status1, count1);
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || count1 !== 6'd63 || status1 !== 2'd2) begin
            errors++;
            $display("FAIL ovfl_hold: done=%b count=%0d status=%0d, want 1 63 2", done1, count1, status1);
        end
        do_ack();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   bad = 0;
        start_val = 6'd0; target = 6'd3; wrap_en = 1'b1; start2 = 1'b1;
        e.st = 2'd1; e.cnt = 6'd62; e.lat = 64; e.t0 = cyc + 1;
        q2.push_back(e);
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (busy2 !== 1'b1 || equal_n2 !== 1'b1 || done2 !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_run: %0d bad RUN cycles, want 0", bad);
        end
        checks++;
        if (done2 !== 1'b1 || status2 !== 2'd1 || equal_n2 !== 1'b1) begin
            errors++;
            $display("FAIL timeout_done: done=%b status=%0d eq_n=%b, want 1 1 1", done2, status2, equal_n2);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (done2 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ack: done=%b, want 0", done2);
        end
    endtask

    task automatic test_reset_mid();
        kick1(6'd0, 6'd40, 1'b0, 0, 2'd0, 6'd0, 0);
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (busy1 !== 1'b1 || count1 !== 6'd9) begin
            errors++;
            $display("FAIL mid_pre: busy=%b count=%0d, want 1 9", busy1, count1);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if (count1 !== 6'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || equal_n1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d busy=%b done=%b eq_n=%b, want 0 0 0 0", count1, busy1, done1, equal_n1);
        end
        // A fresh start must be accepted, proving the FSM is back in IDLE.
        kick1(6'd3, 6'd4, 1'b0, 1, 2'd0, 6'd4, 2);
        wait_done1(10);
        do_ack();
    endtask

    task automatic test_start_ignored();
        kick1(6'd10, 6'd14, 1'b0, 1, 2'd0, 6'd14, 5);
        tick(); tick();
        start_val = 6'd30; target = 6'd20; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || count1 !== 6'd13) begin
            errors++;
            $display("FAIL start_in_run: busy=%b count=%0d, want 1 13", busy1, count1);
        end
        wait_done1(10);
        start_val = 6'd0; target = 6'd0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || count1 !== 6'd14 || equal_n1 !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: done=%b busy=%b count=%0d eq_n=%b, want 1 0 14 0",
                     done1, busy1, count1, equal_n1);
        end
        // ack held high across IDLE and the following RUN.
        ack = 1'b1;
        tick(); tick();
        kick1(6'd20, 6'd21, 1'b0, 1, 2'd0, 6'd21, 2);
        checks++;
        if (busy1 !== 1'b1 || count1 !== 6'd20) begin
            errors++;
            $display("FAIL ack_held_run: busy=%b count=%0d, want 1 20", busy1, count1);
        end
        wait_done1(10);
        tick();
        ack = 1'b0;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL ack_held_idle: done=%b busy=%b, want 0 0", done1, busy1);
        end
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; wrap_en = 1'b0; ack = 1'b0;
        start_val = 6'd0; target = 6'd0;
        test_reset();
        fork monitor(); join_none
        test_plain();
        test_immediate();
        test_wrap_en();
        test_wrap_dis();
        test_timeout();
        test_reset_mid();
        test_start_ignored();
        tick(); tick();
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: q1=%0d q2=%0d pending, want 0 0", q1.size(), q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
